famicom_pad_responder: RTL and testbench
========================================

# famicom_pad_responder

Controller-side responder for the Famicom serial game-pad protocol driven by the Gigatron shell. It samples the 8-bit MiSTer joystick word on `clk_sys` and answers the shell's `famicom_latch`/`famicom_pulse` strobes with an active-low serial bit stream on `famicom_data`, as a real 4021-based pad would. It sits in `emu` between the `hps_io` joystick output and the shell's controller pins.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `famicom_latch` and `famicom_pulse`. Minimum 2.
- `TURBO_DIV`, default 4: number of completed polls per turbo phase toggle. Used only when `FAMICOM_TURBO_EN` is defined. Minimum 1.

- `clk_sys` in 1: system clock. All logic in this block runs in this single domain.
- `reset_n` in 1: synchronous, active-low reset.
- `joystick` in 8: button states, active-high. Bit assignment: [0] right, [1] left, [2] down, [3] up, [4] A, [5] B, [6] select, [7] start.
- `turbo_a` in 1: turbo-A button, active-high. Ignored unless `FAMICOM_TURBO_EN` is defined.
- `turbo_b` in 1: turbo-B button, active-high. Ignored unless `FAMICOM_TURBO_EN` is defined.
- `famicom_latch` in 1: parallel-load strobe from the shell. Asynchronous to `clk_sys`.
- `famicom_pulse` in 1: shift clock from the shell. Asynchronous to `clk_sys`.
- `famicom_data` out 1: serial data, registered. 0 means pressed.
- `poll_strobe` out 1: one-cycle pulse on each synchronized falling edge of the latch.
- `shift_count` out 4: number of bits shifted since the last load. Saturates at 8.

## Operation

**Synchronization**
- `famicom_latch` and `famicom_pulse` each pass through a `SYNC_STAGES`-deep flop chain.
- One further register per signal holds the previous synchronized value, used for edge detection.

**Shift register**
- The shift register `sr[7:0]` is 8 bits wide.
- Load value: `~{A,B,select,start,up,down,left,right}`.
- `famicom_data` always equals `sr[7]`, so the A bit is presented first.

**Per-cycle priority (highest first)**
1. `reset_n` = 0:
   - `sr` = 8'hFF, `famicom_data` = 1
   - `shift_count` = 0, `poll_strobe` = 0
   - synchronizers = 0, turbo counter and phase = 0
2. Synchronized latch = 1: load `sr` every cycle and set `shift_count` = 0. Pulse edges in this state are ignored, so load wins over a simultaneous pulse edge.
3. Synchronized pulse rising edge while latch = 0:
   - `sr` <= `{sr[6:0],1'b1}`
   - `shift_count` increments, saturating at 8
4. Otherwise: hold.

**Other rules**
- Beyond 8 pulses, `famicom_data` stays at 1 (released), matching an official pad.
- `poll_strobe` = 1 for exactly one cycle when the synchronized latch goes 1→0.
- Opposing directions (up+down, left+right) pass through unmodified.
- Joystick changes during a shift sequence have no effect until the next load.
- Reset mid-sequence: all outputs return to their reset values on the next edge. The next poll must start with a latch.

## Timing
- Latch rise → `famicom_data` = new A bit: `SYNC_STAGES`+1 `clk_sys` edges after the transition is first sampled.
- Pulse rise → next bit on `famicom_data`: same `SYNC_STAGES`+1 edges.
- Latch fall → `poll_strobe`: `SYNC_STAGES`+1 edges.
- Input constraint: latch and pulse high and low times must each be ≥ `SYNC_STAGES`+1 `clk_sys` periods. The shell's rates satisfy this by a wide margin.
- `shift_count` updates in the same cycle as `sr`.

## Configuration
- Macro: `FAMICOM_TURBO_EN`.
- Defined:
  - A 16-bit poll counter increments on each `poll_strobe`.
  - When the counter reaches `TURBO_DIV`-1, it wraps to 0 and `turbo_phase` toggles.
  - The effective A used at load is `joystick[4] | (turbo_a & turbo_phase)`; B likewise uses `joystick[5] | (turbo_b & turbo_phase)`.
  - Counter and phase reset to 0.
- Undefined: counter and phase are not instantiated, `turbo_a`/`turbo_b` are unused, and A/B come directly from `joystick[4]`/`joystick[5]`.

## Test plan
- **Reset values:** hold `reset_n`=0 with random inputs, then release → `famicom_data`=1, `shift_count`=0, `poll_strobe`=0.
- **Full poll:** `joystick`=8'b1001_0001 (start, A, right); latch pulse, then 8 pulses → serial 0,1,1,0,1,1,1,0. `poll_strobe` fires once. `shift_count` ends at 8.
- **Over-clocking:** after the 8 bits above, 4 more pulses → `famicom_data` stays 1 and `shift_count` stays 8.
- **Load priority:** pulse rising in the same `clk_sys` cycle as latch rising, with `joystick`=8'h10 → `famicom_data`=0 (A) after the load and `shift_count`=0.
- **Reset mid-sequence:** `reset_n`=0 for one cycle after 3 shifts → `famicom_data`=1 and `shift_count`=0; the next latch reloads normally.
- **Turbo (`FAMICOM_TURBO_EN`, `TURBO_DIV`=2):** `turbo_a`=1, `joystick`=0, 8 polls → first bit reads 1,1,0,0,1,1,0,0.

Source files
------------

// File: rtl/famicom_pad_responder.sv
// Famicom game-pad responder: answers the shell's latch/pulse strobes with the 4021-style
// active-low serial button stream. Optional turbo A/B is enabled with `define FAMICOM_TURBO_EN.
module famicom_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_DIV   = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] joystick,
    input  logic       turbo_a,
    input  logic       turbo_b,
    input  logic       famicom_latch,
    input  logic       famicom_pulse,
    output logic       famicom_data,
    output logic       poll_strobe,
    output logic [3:0] shift_count
);

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] pulse_sync;
    logic                   latch_prev;
    logic                   pulse_prev;
    logic                   latch_s;
    logic                   pulse_s;
    logic                   pulse_rise;
    logic [7:0]             sr;
    logic [7:0]             load_val;
    logic                   a_eff;
    logic                   b_eff;

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync[SYNC_STAGES-1];
    assign pulse_rise = pulse_s & ~pulse_prev;

`ifdef FAMICOM_TURBO_EN
    logic [15:0] poll_cnt;
    logic        turbo_phase;

    // Phase advances once every TURBO_DIV completed polls, so turbo buttons blink per poll group.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            poll_cnt    <= 16'd0;
            turbo_phase <= 1'b0;
        end else if (poll_strobe) begin
            if (poll_cnt == 16'(TURBO_DIV - 1)) begin
                poll_cnt    <= 16'd0;
                turbo_phase <= ~turbo_phase;
            end else begin
                poll_cnt <= poll_cnt + 16'd1;
            end
        end
    end

    assign a_eff = joystick[4] | (turbo_a & turbo_phase);
    assign b_eff = joystick[5] | (turbo_b & turbo_phase);
`else
    logic unused_turbo;

    assign unused_turbo = turbo_a ^ turbo_b;
    assign a_eff        = joystick[4];
    assign b_eff        = joystick[5];
`endif

    // Serial order is A, B, select, start, up, down, left, right; 0 means pressed.
    assign load_val = ~{a_eff, b_eff, joystick[6], joystick[7],
                        joystick[3], joystick[2], joystick[1], joystick[0]};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            latch_sync  <= '0;
            pulse_sync  <= '0;
            latch_prev  <= 1'b0;
            pulse_prev  <= 1'b0;
            poll_strobe <= 1'b0;
            sr          <= 8'hFF;
            shift_count <= 4'd0;
        end else begin
            latch_sync  <= {latch_sync[SYNC_STAGES-2:0], famicom_latch};
            pulse_sync  <= {pulse_sync[SYNC_STAGES-2:0], famicom_pulse};
            latch_prev  <= latch_s;
            pulse_prev  <= pulse_s;
            poll_strobe <= latch_prev & ~latch_s;
            // A held latch reloads every cycle and swallows any pulse edge.
            if (latch_s) begin
                sr          <= load_val;
                shift_count <= 4'd0;
            end else if (pulse_rise) begin
                sr <= {sr[6:0], 1'b1};
                if (shift_count != 4'd8) begin
                    shift_count <= shift_count + 4'd1;
                end
            end
        end
    end

    assign famicom_data = sr[7];

endmodule

// File: tb/tb_famicom_pad_responder.sv
// Bench for famicom_pad_responder: random polls scored against a button-order reference model.
// Define FAMICOM_TURBO_EN for both files to exercise turbo.
module tb_famicom_pad_responder;

    localparam int SYNC = 2;
    localparam int TDIV = 2;
    localparam int LAT  = SYNC + 1;
    localparam int W    = 37;
    localparam int ORDER [8] = '{4, 5, 6, 7, 3, 2, 1, 0};

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] joystick = 8'h00;
    logic       turbo_a = 1'b0;
    logic       turbo_b = 1'b0;
    logic       famicom_latch = 1'b0;
    logic       famicom_pulse = 1'b0;
    logic       famicom_data;
    logic       poll_strobe;
    logic [3:0] shift_count;

    famicom_pad_responder #(
        .SYNC_STAGES(SYNC),
        .TURBO_DIV  (TDIV)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .joystick     (joystick),
        .turbo_a      (turbo_a),
        .turbo_b      (turbo_b),
        .famicom_latch(famicom_latch),
        .famicom_pulse(famicom_pulse),
        .famicom_data (famicom_data),
        .poll_strobe  (poll_strobe),
        .shift_count  (shift_count)
    );

    // clock / cycle counter
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // scoreboard: {due cycle, expected data, expected count}
    logic [W-1:0] exp_q[$];
    int           strobe_q[$];
    int           checks = 0;
    int           errors = 0;

    // reference model: loaded active-high word, bits shifted since load, polls since reset
    logic [7:0] m_word = 8'h00;
    int         m_n = 0;
    int         m_polls = 0;

    function automatic logic m_bit();
        logic [7:0] w;
        w = m_word;
        if (m_n >= 8) return 1'b1;
        return ~w[ORDER[m_n]];
    endfunction

    function automatic logic [3:0] m_cnt();
        return (m_n > 8) ? 4'd8 : 4'(m_n);
    endfunction

    task automatic push_exp(input int due);
        exp_q.push_back({32'(due), m_bit(), m_cnt()});
    endtask

    // monitor
    logic [W-1:0] mon_e;
    int           mon_due;
    always @(negedge clk_sys) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q[0];
            mon_due = int'(mon_e[36:5]);
            if (mon_due == cyc) begin
                void'(exp_q.pop_front());
                checks += 2;
                if (famicom_data !== mon_e[4]) begin
                    errors++;
                    $display("FAIL data cyc=%0d got=%b exp=%b", cyc, famicom_data, mon_e[4]);
                end
                if (shift_count !== mon_e[3:0]) begin
                    errors++;
                    $display("FAIL shift_count cyc=%0d got=%0d exp=%0d", cyc, shift_count, mon_e[3:0]);
                end
            end else if (mon_due < cyc) begin
                void'(exp_q.pop_front());
                checks++;
                errors++;
                $display("FAIL missed_check due=%0d cyc=%0d", mon_due, cyc);
            end
        end
        if (poll_strobe === 1'b1) begin
            checks++;
            if (strobe_q.size() > 0 && strobe_q[0] == cyc) begin
                void'(strobe_q.pop_front());
            end else begin
                errors++;
                $display("FAIL poll_strobe_unexpected cyc=%0d got=1 exp=0", cyc);
            end
        end else if (strobe_q.size() > 0 && strobe_q[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL poll_strobe_missing cyc=%0d got=%b exp=1", cyc, poll_strobe);
            void'(strobe_q.pop_front());
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic model_load();
        int phase;
        m_word = joystick;
        phase  = (m_polls / TDIV) % 2;
`ifdef FAMICOM_TURBO_EN
        m_word[4] = m_word[4] | (turbo_a & phase[0]);
        m_word[5] = m_word[5] | (turbo_b & phase[0]);
`endif
        m_n = 0;
    endtask

    task automatic do_latch(input logic with_pulse);
        famicom_latch = 1'b1;
        famicom_pulse = with_pulse;
        model_load();
        push_exp(cyc + LAT);
        tick($urandom_range(LAT, LAT + 3));
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;
        strobe_q.push_back(cyc + LAT);
        m_polls++;
        tick(LAT + 2);
    endtask

    task automatic do_pulse();
        famicom_pulse = 1'b1;
        m_n++;
        push_exp(cyc + LAT);
        joystick = 8'($urandom);
        tick($urandom_range(LAT, LAT + 2));
        famicom_pulse = 1'b0;
        tick($urandom_range(LAT, LAT + 2));
    endtask

    task automatic model_reset();
        m_word  = 8'h00;
        m_n     = 0;
        m_polls = 0;
    endtask

    task automatic do_reset(input int n);
        reset_n       = 1'b0;
        joystick      = 8'($urandom);
        turbo_a       = 1'($urandom);
        turbo_b       = 1'($urandom);
        famicom_latch = 1'($urandom);
        famicom_pulse = 1'($urandom);
        tick(n);
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;
        tick(LAT);
        model_reset();
        push_exp(cyc);
        reset_n = 1'b1;
        push_exp(cyc + 1);
        tick(3);
    endtask

    initial begin
        tick(1);
        do_reset($urandom_range(3, 8));

        // full poll, then over-clocking
        turbo_a  = 1'b0;
        turbo_b  = 1'b0;
        joystick = 8'b1001_0001;
        do_latch(1'b0);
        for (int i = 0; i < 12; i++) do_pulse();

        // latch and pulse rise together
        joystick = 8'h10;
        do_latch(1'b1);
        for (int i = 0; i < 3; i++) do_pulse();

        // one-cycle reset mid-sequence, then a normal reload
        reset_n = 1'b0;
        model_reset();
        push_exp(cyc + 1);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        joystick = 8'h6C;
        do_latch(1'b0);
        for (int i = 0; i < 8; i++) do_pulse();

        // random polls
        for (int p = 0; p < 20; p++) begin
            joystick = 8'($urandom);
            turbo_a  = 1'($urandom);
            turbo_b  = 1'($urandom);
            do_latch(1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 11)); i++) do_pulse();
        end

`ifdef FAMICOM_TURBO_EN
        do_reset(4);
        turbo_a = 1'b1;
        turbo_b = 1'b0;
        for (int p = 0; p < 8; p++) begin
            joystick = 8'h00;
            do_latch(1'b0);
        end
`endif

        for (int i = 0; i < 50 && (exp_q.size() > 0 || strobe_q.size() > 0); i++) tick(1);
        checks++;
        if (exp_q.size() > 0 || strobe_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size() + strobe_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
